sa_hs_cdc_rx: RTL and testbench

SA_HS_CDC_RX -- requirements
Module: sa_hs_cdc_rx

---
 rtl/sa_cdc_pkg.sv | 30 +++
 rtl/sa_sync_bit.sv | 37 +++
 rtl/sa_hs_cdc_rx.sv | 117 +++++++++++
 tb/tb_sa_hs_cdc_rx.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sa_cdc_pkg.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// sa_cdc_pkg
// Shared definitions for the 4-phase handshake CDC receiver.
//   state_e      : receiver FSM encoding (IDLE=0, VALID=1, ACK=2; 3 unused)
//   XFER_CNT_W   : width of the completed-transfer counter
//   sat_inc()    : saturating increment for the transfer counter
// ---------------------------------------------------------------------------
package sa_cdc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        VALID = 2'd1,
        ACK   = 2'd2
    } state_e;

    localparam int XFER_CNT_W = 16;

    // Counter sticks at all-ones instead of wrapping back to zero.
    function automatic logic [XFER_CNT_W-1:0] sat_inc(input logic [XFER_CNT_W-1:0] v);
        logic [XFER_CNT_W-1:0] r;
        if (&v) begin
            r = v;
        end else begin
            r = v + 1'b1;
        end
        return r;
    endfunction

endpackage

// File: rtl/sa_sync_bit.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// sa_sync_bit
// Single-bit multi-flop synchronizer with asynchronous clear to 0.
//   clk  : destination clock
//   clr_ : asynchronous active-low clear of every stage
//   d    : asynchronous input
//   q    : synchronized output (last stage)
// ---------------------------------------------------------------------------
module sa_sync_bit #(
    parameter int STAGES = 3
) (
    input  logic clk,
    input  logic clr_,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    // Shift towards the MSB; bit 0 is the metastability-catching stage.
    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d};
    end

    always_ff @(posedge clk or negedge clr_) begin
        if (!clr_) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/sa_hs_cdc_rx.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// sa_hs_cdc_rx
// Receive side of a 4-phase req/ack clock-domain crossing. The request is
// synchronized; the data bus is not, and is sampled only on the edge where
// the FSM leaves IDLE (the sender holds it stable while req is high).
//   clk        : receive-domain clock
//   clr_       : asynchronous active-low reset
//   req_async  : 4-phase request from the sender (unsynchronized)
//   data_async : sender data, stable while req_async=1
//   ack        : 4-phase acknowledge back to the sender (flop output)
//   out_valid  : captured word available downstream
//   out_ready  : downstream accepts the word
//   out_data   : captured word
//   xfer_cnt   : completed-transfer count, saturating at all-ones
//
// Downstream handshake: a word moves on a clk edge where out_valid and
// out_ready are both 1; out_valid/out_data stay fixed until that edge and
// out_ready has no effect while out_valid is 0.
// ---------------------------------------------------------------------------
module sa_hs_cdc_rx
    import sa_cdc_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int SYNC_STAGES = 3
) (
    input  logic                  clk,
    input  logic                  clr_,
    input  logic                  req_async,
    input  logic [WIDTH-1:0]      data_async,
    output logic                  ack,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WIDTH-1:0]      out_data,
    output logic [XFER_CNT_W-1:0] xfer_cnt
);

    logic req_s;

    sa_sync_bit #(
        .STAGES (SYNC_STAGES)
    ) u_req_sync (
        .clk  (clk),
        .clr_ (clr_),
        .d    (req_async),
        .q    (req_s)
    );

    state_e                  state_q,     state_d;
    logic                    ack_q,       ack_d;
    logic                    out_valid_q, out_valid_d;
    logic [WIDTH-1:0]        out_data_q,  out_data_d;
    logic [XFER_CNT_W-1:0]   xfer_cnt_q,  xfer_cnt_d;

    always_comb begin
        state_d     = state_q;
        ack_d       = ack_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        xfer_cnt_d  = xfer_cnt_q;

        case (state_q)
            IDLE: begin
                if (req_s) begin
                    out_data_d  = data_async;
                    out_valid_d = 1'b1;
                    state_d     = VALID;
                end
            end
            VALID: begin
                // A falling req_s here is a sender error; it is ignored and
                // the word is still delivered and acknowledged.
                if (out_valid_q && out_ready) begin
                    out_valid_d = 1'b0;
                    ack_d       = 1'b1;
                    xfer_cnt_d  = sat_inc(xfer_cnt_q);
                    state_d     = ACK;
                end
            end
            ACK: begin
                // Staying here while req_s is high is what blocks a second
                // capture of the same request.
                if (!req_s) begin
                    ack_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                ack_d       = 1'b0;
                out_valid_d = 1'b0;
                state_d     = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge clr_) begin
        if (!clr_) begin
            state_q     <= IDLE;
            ack_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            xfer_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            ack_q       <= ack_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            xfer_cnt_q  <= xfer_cnt_d;
        end
    end

    assign ack       = ack_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign xfer_cnt  = xfer_cnt_q;

endmodule

// File: tb/tb_sa_hs_cdc_rx.sv
`timescale 1ns/1ps
// Bench for sa_hs_cdc_rx. Edge numbering: the first rising clk edge that
// samples a newly raised req_async is edge 1; with 3 sync stages the word
// shows up after edge 4 and ack after edge 5 (out_ready held high).
module tb_sa_hs_cdc_rx;

    localparam int W = 32;

    logic          clk;
    logic          clr_;
    logic          req_async;
    logic [W-1:0]  data_async;
    logic          ack;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_data;
    logic [15:0]   xfer_cnt;

    int            checks;
    int            failures;
    logic [W-1:0]  exp_q[$];
    logic [15:0]   cnt_model;
    bit            rand_en;

    sa_hs_cdc_rx #(
        .WIDTH       (W),
        .SYNC_STAGES (3)
    ) dut (
        .clk        (clk),
        .clr_       (clr_),
        .req_async  (req_async),
        .data_async (data_async),
        .ack        (ack),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .xfer_cnt   (xfer_cnt)
    );

    // ---------------- clock / watchdog ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2ms;
        failures++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Ticks until ack equals lvl; n returns the number of edges taken.
    task automatic wait_ack(input logic lvl, input string name, output int n);
        n = 0;
        while (ack !== lvl && n < 50) begin
            tick(1);
            n++;
        end
        if (ack !== lvl) fail_now(name);
    endtask

    task automatic do_reset();
        clr_ = 1'b0;
        cnt_model = '0;
        tick(2);
        clr_ = 1'b1;
    endtask

    // Complete one aligned transfer with out_ready assumed high.
    task automatic xfer(input logic [W-1:0] d);
        int n;
        data_async = d;
        exp_q.push_back(d);
        req_async = 1'b1;
        wait_ack(1'b1, "xfer_ack_rise_timeout", n);
        req_async = 1'b0;
        wait_ack(1'b0, "xfer_ack_fall_timeout", n);
        tick(1);
    endtask

    // Sender in its own time base: per is its clock period in ns.
    task automatic rand_sender(input realtime per, input int nwords);
        int n;
        for (int i = 0; i < nwords; i++) begin
            #(per * $urandom_range(1, 3));
            data_async = $urandom;
            #(per);
            exp_q.push_back(data_async);
            req_async = 1'b1;
            n = 0;
            while (ack !== 1'b1 && n < 2000) begin
                #(per);
                n++;
            end
            if (ack !== 1'b1) begin
                fail_now("rand_ack_rise_timeout");
                req_async = 1'b0;
                return;
            end
            #(per);
            req_async = 1'b0;
            n = 0;
            while (ack !== 1'b0 && n < 2000) begin
                #(per);
                n++;
            end
            if (ack !== 1'b0) begin
                fail_now("rand_ack_fall_timeout");
                return;
            end
        end
    endtask

    // ---------------- scoreboard monitor ----------------
    // out_ready only changes just after a rising edge, so the value seen at
    // the falling edge is the one the next rising edge acts on.
    initial begin
        logic [W-1:0] e;
        forever begin
            @(negedge clk);
            if (clr_ === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
                if (exp_q.size() == 0) begin
                    fail_now("sb_unexpected_word");
                end else begin
                    e = exp_q.pop_front();
                    chk("sb_data", out_data, e);
                    if (cnt_model != 16'hFFFF) cnt_model = cnt_model + 16'd1;
                    @(posedge clk);
                    #1;
                    if (clr_ === 1'b1) begin
                        chk("sb_xfer_cnt", {16'd0, xfer_cnt}, {16'd0, cnt_model});
                        chk("sb_ack_after_accept", {31'd0, ack}, 32'd1);
                        chk("sb_valid_after_accept", {31'd0, out_valid}, 32'd0);
                    end
                end
            end
        end
    end

    // ---------------- random out_ready driver ----------------
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_en) out_ready = 1'($urandom_range(0, 1));
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int n;
        checks     = 0;
        failures   = 0;
        cnt_model  = '0;
        rand_en    = 1'b0;
        clr_       = 1'b1;
        req_async  = 1'b1;
        data_async = 32'h1234_5678;
        out_ready  = 1'b1;

        // Reset with req already high: outputs clear without any clock edge.
        #1;
        clr_ = 1'b0;
        #2;
        chk("rst_ack",       {31'd0, ack},       32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_data",  out_data,           32'd0);
        chk("rst_xfer_cnt",  {16'd0, xfer_cnt},  32'd0);
        chk("rst_state",     {30'd0, dut.state_q}, 32'd0);
        tick(2);
        exp_q.push_back(32'h1234_5678);
        clr_ = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            tick(1);
            chk($sformatf("rst_release_valid_e%0d", i), {31'd0, out_valid}, (i == 4) ? 32'd1 : 32'd0);
        end
        req_async = 1'b0;
        wait_ack(1'b0, "rst_ack_fall_timeout", n);
        tick(2);

        // Basic transfer from a clean reset.
        do_reset();
        data_async = 32'hDEAD_BEEF;
        exp_q.push_back(32'hDEAD_BEEF);
        req_async  = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            tick(1);
            chk($sformatf("basic_valid_e%0d", i), {31'd0, out_valid}, (i == 4) ? 32'd1 : 32'd0);
            chk($sformatf("basic_ack_e%0d", i),   {31'd0, ack},       (i == 5) ? 32'd1 : 32'd0);
        end
        chk("basic_out_data", out_data, 32'hDEAD_BEEF);
        chk("basic_xfer_cnt", {16'd0, xfer_cnt}, 32'd1);
        req_async = 1'b0;
        wait_ack(1'b0, "basic_ack_fall_timeout", n);
        checks++;
        if (n < 3 || n > 4) begin
            failures++;
            $display("FAIL basic_ack_fall_edges: got %0d expected 3..4", n);
        end
        tick(2);

        // Back-pressure, then req held high in ACK must not start a new word.
        out_ready  = 1'b0;
        data_async = 32'hA5A5_0001;
        exp_q.push_back(32'hA5A5_0001);
        req_async  = 1'b1;
        tick(4);
        chk("bp_valid_rise", {31'd0, out_valid}, 32'd1);
        for (int i = 0; i < 10; i++) begin
            tick(1);
            chk("bp_valid_hold", {31'd0, out_valid}, 32'd1);
            chk("bp_data_hold",  out_data,           32'hA5A5_0001);
            chk("bp_ack_low",    {31'd0, ack},       32'd0);
        end
        out_ready = 1'b1;
        tick(1);
        chk("bp_ack_rise",   {31'd0, ack},       32'd1);
        chk("bp_xfer_cnt",   {16'd0, xfer_cnt},  32'd2);
        for (int i = 0; i < 6; i++) begin
            tick(1);
            chk("ack_hold_no_recapture", {31'd0, out_valid}, 32'd0);
            chk("ack_hold_ack",          {31'd0, ack},       32'd1);
        end
        req_async = 1'b0;
        wait_ack(1'b0, "bp_ack_fall_timeout", n);
        tick(2);

        // Reset while in ACK with req held high: second capture, count restarts.
        data_async = 32'h0BAD_F00D;
        exp_q.push_back(32'h0BAD_F00D);
        req_async  = 1'b1;
        tick(5);
        chk("mid_ack_before_rst", {31'd0, ack}, 32'd1);
        chk("mid_cnt_before_rst", {16'd0, xfer_cnt}, 32'd3);
        #2;
        clr_ = 1'b0;
        cnt_model = '0;
        #1;
        chk("mid_rst_ack",   {31'd0, ack},         32'd0);
        chk("mid_rst_state", {30'd0, dut.state_q}, 32'd0);
        chk("mid_rst_cnt",   {16'd0, xfer_cnt},    32'd0);
        tick(2);
        exp_q.push_back(32'h0BAD_F00D);
        clr_ = 1'b1;
        tick(4);
        chk("mid_recapture_valid", {31'd0, out_valid}, 32'd1);
        tick(1);
        chk("mid_recapture_ack", {31'd0, ack},      32'd1);
        chk("mid_recapture_cnt", {16'd0, xfer_cnt}, 32'd1);
        req_async = 1'b0;
        wait_ack(1'b0, "mid_ack_fall_timeout", n);
        tick(2);

        // Saturation: preload the counter just below the top.
        force dut.xfer_cnt_q = 16'hFFFE;
        #2;
        release dut.xfer_cnt_q;
        cnt_model = 16'hFFFE;
        tick(1);
        chk("sat_preload", {16'd0, xfer_cnt}, 32'h0000_FFFE);
        xfer(32'h0000_0001);
        xfer(32'h0000_0002);
        xfer(32'h0000_0003);
        chk("sat_final", {16'd0, xfer_cnt}, 32'h0000_FFFF);

        // Random sender at several clock ratios (rx period 10 ns).
        do_reset();
        tick(1);
        rand_en = 1'b1;
        rand_sender(33.0, 250);
        rand_sender(15.0, 250);
        rand_sender(7.0,  250);
        rand_sender(3.4,  250);
        rand_en = 1'b0;
        tick(1);
        out_ready = 1'b1;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            tick(1);
            n++;
        end
        tick(2);
        chk("rand_queue_drained", exp_q.size(), 32'd0);
        chk("rand_xfer_cnt", {16'd0, xfer_cnt}, 32'd1000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
